// File: rtl/link_pkg.sv
// Shared widths, word/beat types and config helpers for the DDR downstream receive path.
package link_pkg;

  localparam int LINK_CHANNEL_WIDTH = 8;
  localparam int LINK_NUM_CHANNELS  = 2;
  localparam int LINK_CORE_WIDTH    = 64;
  localparam int LINK_FIFO_DEPTH    = 8;
  localparam int LINK_TOKEN_RATIO   = 4;

  localparam int BEAT_WIDTH  = LINK_NUM_CHANNELS * LINK_CHANNEL_WIDTH;
  localparam int BEATS       = LINK_CORE_WIDTH / BEAT_WIDTH;
  localparam int FIFO_CNT_W  = $clog2(LINK_FIFO_DEPTH) + 1;

  typedef logic [BEAT_WIDTH-1:0]      beat_t;
  typedef logic [LINK_CORE_WIDTH-1:0] word_t;

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/link_rx_fifo.sv
// Core-word buffer: push lands next cycle, head read combinationally from storage.
// A push while full is taken only if a pop happens in the same cycle; otherwise it is refused.
module link_rx_fifo
  import link_pkg::*;
#(
  parameter int WIDTH = LINK_CORE_WIDTH,
  parameter int DEPTH = LINK_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_chk_depth
    $error("link_rx_fifo: DEPTH must be a power of 2 and at least 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage is not reset; contents are only observable behind a valid count.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/link_ddr_downstream_rx.sv
// Reassembles lock-step link beats into core words, buffers them and returns one credit per TOKEN_RATIO pops.
// Final beat to core_valid_o is 1 cycle; a word completing into a full FIFO without a pop is dropped and flagged.
module link_ddr_downstream_rx
  import link_pkg::*;
#(
  parameter int CHANNEL_WIDTH = LINK_CHANNEL_WIDTH,
  parameter int NUM_CHANNELS  = LINK_NUM_CHANNELS,
  parameter int CORE_WIDTH    = LINK_CORE_WIDTH,
  parameter int FIFO_DEPTH    = LINK_FIFO_DEPTH,
  parameter int TOKEN_RATIO   = LINK_TOKEN_RATIO
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_CHANNELS-1:0]               link_valid_i,
  input  logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0] link_data_i,
  output logic                                  core_valid_o,
  output logic [CORE_WIDTH-1:0]                 core_data_o,
  input  logic                                  core_ready_i,
  output logic                                  token_o,
  output logic                                  overflow_o,
  output logic                                  misalign_o
);

  localparam int BEAT_W = NUM_CHANNELS * CHANNEL_WIDTH;
  localparam int NBEATS = CORE_WIDTH / BEAT_W;
  localparam int BCW    = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int TCW    = (TOKEN_RATIO > 1) ? $clog2(TOKEN_RATIO) : 1;

  if (CORE_WIDTH % BEAT_W != 0) begin : g_chk_width
    $error("link_ddr_downstream_rx: CORE_WIDTH must be a multiple of the beat width");
  end
  if (TOKEN_RATIO < 1 || FIFO_DEPTH % TOKEN_RATIO != 0) begin : g_chk_ratio
    $error("link_ddr_downstream_rx: TOKEN_RATIO must divide FIFO_DEPTH");
  end

  logic [BCW-1:0]        beat_q, beat_d;
  logic [CORE_WIDTH-1:0] shift_q, word_d;
  logic [TCW-1:0]        tok_cnt_q, tok_cnt_d;
  logic                  token_q, overflow_q, misalign_q;
  logic                  beat_acc, beat_bad, last_beat, push, pop, tok_wrap;
  logic                  fifo_full, fifo_empty;

  assign beat_acc  = &link_valid_i;
  assign beat_bad  = (|link_valid_i) && !beat_acc;
  assign last_beat = (beat_q == BCW'(NBEATS - 1));
  assign push      = beat_acc && last_beat;
  assign pop       = core_valid_o && core_ready_i;
  assign tok_wrap  = (tok_cnt_q == TCW'(TOKEN_RATIO - 1));

  // The completing word is the held beats with the current beat dropped into its slot.
  always_comb begin
    word_d = shift_q;
    for (int k = 0; k < NBEATS; k++) begin
      if (beat_q == BCW'(k)) word_d[k*BEAT_W +: BEAT_W] = link_data_i;
    end
  end

  always_comb begin
    beat_d = beat_q;
    if (beat_acc) beat_d = last_beat ? '0 : beat_q + BCW'(1);
  end

  always_comb begin
    tok_cnt_d = tok_cnt_q;
    if (pop) tok_cnt_d = tok_wrap ? '0 : tok_cnt_q + TCW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_q     <= '0;
      shift_q    <= '0;
      tok_cnt_q  <= '0;
      token_q    <= 1'b0;
      overflow_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      beat_q    <= beat_d;
      tok_cnt_q <= tok_cnt_d;
      token_q   <= pop && tok_wrap;
      if (beat_acc) shift_q <= word_d;
      if (push && fifo_full && !pop) overflow_q <= 1'b1;
      if (beat_bad) misalign_q <= 1'b1;
    end
  end

  link_rx_fifo #(
    .WIDTH (CORE_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (word_d),
    .pop_i       (pop),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (core_data_o)
  );

  assign core_valid_o = !fifo_empty;
  assign token_o      = token_q;
  assign overflow_o   = overflow_q;
  assign misalign_o   = misalign_q;

endmodule

// File: doc/link_ddr_downstream_rx.md
Name: link_ddr_downstream_rx

Overview:
- Single-clock receive stage that consumes the per-channel link flits produced by the DDR upstream link.
- Reassembles each group of link beats into one core word and buffers the words in a small FIFO.
- Presents the words to the core side with a valid/ready handshake.
- Returns credit tokens to the upstream sender as FIFO entries are drained. This closes the upstream sent-count/finish-count loop.

Parameters:
- CHANNEL_WIDTH, 8: data bits per channel per beat.
- NUM_CHANNELS, 2: parallel link channels.
- CORE_WIDTH, 64: reassembled core word width. Must be a multiple of CHANNEL_WIDTH*NUM_CHANNELS.
- FIFO_DEPTH, 8: core-word buffer entries. Power of 2.
- TOKEN_RATIO, 4: core words drained per returned token. Must divide FIFO_DEPTH.

Ports:
- clk  in  1  sole clock.
- rst_n  in  1  synchronous, active-low reset.
- link_valid_i  in  NUM_CHANNELS  per-channel beat valid.
- link_data_i  in  NUM_CHANNELS*CHANNEL_WIDTH  beat data. Channel c occupies bits [c*CW +: CW].
- core_valid_o  out  1  FIFO head valid.
- core_data_o  out  CORE_WIDTH  FIFO head word.
- core_ready_i  in  1  core accepts the head word.
- token_o  out  1  one-cycle credit-return pulse.
- overflow_o  out  1  sticky: a completed word was dropped because the FIFO was full.
- misalign_o  out  1  sticky: channel valids disagreed on a beat.

Behaviour:
- Interface (already decided): one clock; reset is synchronous and active-low.
- Derived constant: BEATS = CORE_WIDTH/(NUM_CHANNELS*CHANNEL_WIDTH), default 4.
- Reset (rst_n=0 sampled at clk edge):
  - Clears the beat counter, shift register, FIFO pointers/count and token counter.
  - Clears overflow_o and misalign_o.
  - core_valid_o=0, token_o=0. core_data_o is don't-care, driven from the storage array.
- Reset mid-word discards the partial word. Reset with a non-empty FIFO discards all entries and returns no tokens.
- Beat acceptance:
  - A beat is accepted when all link_valid_i bits are 1.
  - If all bits are 0: idle, no effect.
  - Any other pattern: beat dropped, misalign_o set the next cycle, beat counter unchanged.
- Assembly:
  - Beat k (0..BEATS-1) is written to core-word bits [k*NUM_CHANNELS*CW +: NUM_CHANNELS*CW]. Beat 0 is the least significant.
  - The beat counter wraps from BEATS-1 to 0.
- Push:
  - Occurs in the cycle the final beat is accepted. The word is written straight from the shift register plus the current beat.
  - The word is visible on core_valid_o/core_data_o the next cycle.
  - Latency from the final beat to core_valid_o is 1 cycle when the FIFO was empty.
- Pop: core_valid_o && core_ready_i. The head advances next cycle. core_data_o must hold stable while core_valid_o=1 and core_ready_i=0.
- FIFO full (count==FIFO_DEPTH):
  - A push in the same cycle as a pop is accepted; count is unchanged.
  - A push without a pop is dropped, overflow_o set, and the beat counter still wraps to 0.
- Empty: core_valid_o=0. A push into an empty FIFO is not bypassed combinationally.
- Count width is clog2(FIFO_DEPTH)+1. Pointers are clog2(FIFO_DEPTH) bits and wrap naturally.
- Tokens:
  - A token counter of clog2(TOKEN_RATIO) bits increments on each pop.
  - On a pop with counter==TOKEN_RATIO-1: token_o=1 for exactly the next cycle, and the counter wraps to 0.
  - Back-to-back batches yield a token_o pulse per batch, with no merging.
- Sticky flags clear only on reset.

Decomposition:
- Package link_pkg:
  - Constants BEATS, BEAT_WIDTH = NUM_CHANNELS*CHANNEL_WIDTH, and the FIFO count width.
  - A typedef for a beat and for a core word.
  - Elaboration checks for divisibility and the power-of-2 depth.
- Sub-module link_rx_fifo holds the FIFO_DEPTH x CORE_WIDTH storage with pointers/count, push/pop/full/empty, and same-cycle push-when-full rule.
- Assembly, error flags and token logic stay in the top.

Test Plan:
- Reset, then 4 beats of data 0x0201, 0x0403, 0x0605, 0x0807 with link_valid_i=2'b11 and core_ready_i=1 → one cycle after beat 4, core_valid_o=1 and core_data_o=0x0807_0605_0403_0201; it pops; no token yet.
- 16 words streamed with core_ready_i=1 → exactly 4 token_o pulses, each 1 cycle after the 4th, 8th, 12th and 16th pop; overflow_o=0.
- core_ready_i=0, 9 complete words sent → FIFO holds words 1..8; overflow_o=1 after word 9; then ready=1 drains words 1..8 in order with 2 token pulses.
- FIFO full (8 words), word 9 completes in the same cycle as a pop → accepted; count stays 8; overflow_o remains 0; word 9 appears last.
- link_valid_i=2'b01 in the middle of a word → misalign_o=1; beat counter unchanged; the following 2'b11 beats complete the word correctly.
- rst_n=0 for 1 cycle after 2 beats and 3 buffered words → core_valid_o=0, no token; the next 4 beats form a fresh word starting at beat 0.
